// File: rtl/mod997_seq_reducer_pkg.sv
// Shared constants and types for the sequential mod-997 reducer.
// Operand chunks are folded MSB-first through one shared Horner step.
package mod997_pkg;
  localparam int MOD      = 997;
  localparam int RES_W    = 10;
  localparam int CHUNK_W  = 6;
  localparam int IN_W     = 500;
  localparam int N_CHUNKS = 84;
  localparam int PAD_W    = N_CHUNKS * CHUNK_W;
  localparam int CNT_W    = 7;
  localparam int STEP_W   = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // SUB_K[k] = MOD << k, used by the conditional-subtract ladder
  localparam logic [STEP_W-1:0] SUB_K [0:5] = '{
    16'd997, 16'd1994, 16'd3988, 16'd7976, 16'd15952, 16'd31904
  };
endpackage

// File: rtl/mod997_seq_reducer_if.sv
// Operand-in / residue-out valid-ready bundle for the mod-997 reducer.
interface mod997_seq_reducer_if
  import mod997_pkg::*;
  ;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_residue;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_residue);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_residue);
endinterface

// File: rtl/mod997_seq_reducer_horner_step.sv
// One Horner step: nxt = (acc*64 + chunk) mod 997, purely combinational.
// acc < 997 on entry, so v < 2*(997<<5) and six subtractions suffice.
module mod997_horner_step
  import mod997_pkg::*;
(
  input  logic [RES_W-1:0]   acc,
  input  logic [CHUNK_W-1:0] chunk,
  output logic [RES_W-1:0]   nxt
);
  logic [STEP_W-1:0] v;

  always_comb begin
    v = {acc, chunk};
    for (int k = 5; k >= 0; k--) begin
      if (v >= SUB_K[k]) v = v - SUB_K[k];
    end
    nxt = v[RES_W-1:0];
  end
endmodule

// File: rtl/mod997_seq_reducer.sv
// Sequential operand mod 997: accept, walk 84 six-bit chunks MSB-first, hold result.
// All handshake outputs are registered alongside the state.
module mod997_seq_reducer
  import mod997_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mod997_seq_reducer_if.slave  io,
  output logic                 busy
);
  state_t             state;
  logic [PAD_W-1:0]   shreg;
  logic [RES_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [RES_W-1:0]   nxt;

  mod997_horner_step u_step (
    .acc   (acc),
    .chunk (shreg[PAD_W-1 -: CHUNK_W]),
    .nxt   (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      io.in_ready    <= 1'b1;
      io.out_valid   <= 1'b0;
      io.out_residue <= '0;
      busy           <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      shreg          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            // top pad bits are zero so the first chunk holds only 2 data bits
            shreg       <= {{(PAD_W-IN_W){1'b0}}, io.in_data};
            acc         <= '0;
            cnt         <= '0;
            state       <= RUN;
            io.in_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          acc   <= nxt;
          shreg <= shreg << CHUNK_W;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(N_CHUNKS-1)) begin
            state          <= DONE;
            io.out_residue <= nxt;
            io.out_valid   <= 1'b1;
            busy           <= 1'b0;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state        <= IDLE;
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod997_seq_reducer.sv
// Bench for mod997_seq_reducer: vector table, scoreboard, handshake corner cases,
// and an exhaustive sweep of the Horner step.
module tb_mod997_seq_reducer;
  import mod997_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  mod997_seq_reducer_if bus ();
  mod997_seq_reducer dut (.clk(clk), .rst(rst), .io(bus), .busy(busy));

  logic [RES_W-1:0]   s_acc;
  logic [CHUNK_W-1:0] s_chunk;
  logic [RES_W-1:0]   s_nxt;
  mod997_horner_step u_step_tb (.acc(s_acc), .chunk(s_chunk), .nxt(s_nxt));

  int checks = 0;
  int passes = 0;
  int cur_exp = 0;
  int sb[$];
  int cyc = 0;
  int acc_cyc = 0, hs_cyc = 0;
  int n_acc = 0, n_out = 0;

  typedef struct {
    logic [IN_W-1:0] data;
    int              exp;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // bitwise MSB-first reference, independent of the chunked datapath
  function automatic int ref_mod(input logic [IN_W-1:0] d);
    int r = 0;
    for (int i = IN_W-1; i >= 0; i--) r = (r * 2 + int'(d[i])) % MOD;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: push on input handshake, pop/compare on output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(cur_exp);
        acc_cyc = cyc;
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc = cyc;
        n_out++;
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else check("residue", longint'(bus.out_residue), longint'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [IN_W-1:0] d, input int e);
    int n = 0;
    bus.in_data = d; cur_exp = e; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin tick(); n++; end
    check("in_ready_wait", longint'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    check("busy_run", longint'(busy), 1);
    check("in_ready_run", longint'(bus.in_ready), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 200) begin tick(); n++; end
    check("latency", n, N_CHUNKS);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle_out_valid", longint'(bus.out_valid), 0);
    check("idle_in_ready", longint'(bus.in_ready), 1);
  endtask

  initial begin
    logic [IN_W-1:0] r1, r2;
    int n, a0, o0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_residue", longint'(bus.out_residue), 0);
    check("rst_busy", longint'(busy), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < IN_W; i++) begin
      r1[i] = 1'($urandom_range(0, 1));
      r2[i] = 1'($urandom_range(0, 1));
    end
    tbl[0] = '{data: '0, exp: 0};
    tbl[1] = '{data: IN_W'(1000), exp: 3};
    tbl[2] = '{data: IN_W'(996), exp: 996};
    tbl[3] = '{data: IN_W'(994009), exp: 0};
    tbl[4] = '{data: IN_W'(64), exp: 64};
    tbl[5] = '{data: IN_W'(64'd997 * 64'd123456789), exp: 0};
    tbl[6] = '{data: {IN_W{1'b1}}, exp: ref_mod({IN_W{1'b1}})};
    tbl[7] = '{data: r1, exp: ref_mod(r1)};
    tbl[8] = '{data: r2, exp: ref_mod(r2)};

    for (int i = 0; i < 9; i++) begin
      accept_op(tbl[i].data, tbl[i].exp);
      wait_valid();
      drain();
    end

    // backpressure: residue held with out_ready low
    accept_op(IN_W'(996), 996);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_out_valid", longint'(bus.out_valid), 1);
      check("bp_residue", longint'(bus.out_residue), 996);
      check("bp_in_ready", longint'(bus.in_ready), 0);
    end
    drain();

    // reset in the middle of RUN discards the operand
    accept_op(IN_W'(1000), 3);
    repeat (39) tick();
    check("mid_busy", longint'(busy), 1);
    rst = 1'b1;
    tick();
    check("mrst_out_valid", longint'(bus.out_valid), 0);
    check("mrst_in_ready", longint'(bus.in_ready), 1);
    check("mrst_busy", longint'(busy), 0);
    rst = 1'b0;
    sb.delete();
    accept_op(IN_W'(1000), 3);
    wait_valid();
    drain();

    // back-to-back with in_valid held and out_ready high
    a0 = n_acc; o0 = n_out;
    bus.out_ready = 1'b1;
    bus.in_data = IN_W'(1000); cur_exp = 3; bus.in_valid = 1'b1;
    n = 0;
    while (n_acc < a0 + 1 && n < 300) begin tick(); n++; end
    bus.in_data = IN_W'(5); cur_exp = 5;
    n = 0;
    while (n_acc < a0 + 2 && n < 300) begin tick(); n++; end
    bus.in_valid = 1'b0;
    check("b2b_accepts", n_acc - a0, 2);
    check("b2b_gap", acc_cyc - hs_cyc, 1);
    n = 0;
    while (n_out < o0 + 2 && n < 300) begin tick(); n++; end
    bus.out_ready = 1'b0;
    check("b2b_outputs", n_out - o0, 2);
    check("sb_empty", sb.size(), 0);

    // exhaustive Horner step sweep
    n = 0;
    for (int a = 0; a < MOD; a++) begin
      for (int c = 0; c < 64; c++) begin
        s_acc = RES_W'(a); s_chunk = CHUNK_W'(c);
        #1;
        if (int'(s_nxt) != (a * 64 + c) % MOD) n++;
      end
    end
    check("step_sweep_errors", n, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
